// File: rtl/fetch_unit.sv
// Instruction fetch stage: drives the instruction memory and fills the IF/ID register.
// Handles load-use holds (buffered fetch), branch redirects, and draining of abandoned requests.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        remain_pc,
  input  logic        branch,
  input  logic [31:0] branch_target,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic [31:0] id_inst,
  output logic [31:0] id_pc4,
  output logic        id_valid
);

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    HOLD  = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t      state;
  state_t      state_nxt;

  logic [31:0] pc;
  logic [31:0] pc_nxt;
  logic [31:0] pc_inc;
  logic [31:0] drain_addr;
  logic [31:0] drain_addr_nxt;
  logic [31:0] buf_inst;
  logic [31:0] buf_inst_nxt;
  logic [31:0] buf_pc4;
  logic [31:0] buf_pc4_nxt;
  logic [31:0] id_inst_nxt;
  logic [31:0] id_pc4_nxt;
  logic        id_valid_nxt;

  logic        hold;
  logic        redir;

  // Decode-side controls only mean something while IF/ID holds a real instruction.
  assign hold   = id_valid & stall & remain_pc;
  assign redir  = id_valid & branch & ~hold;
  assign pc_inc = pc + 32'd4;

  always_comb begin
    state_nxt      = state;
    pc_nxt         = pc;
    drain_addr_nxt = drain_addr;
    buf_inst_nxt   = buf_inst;
    buf_pc4_nxt    = buf_pc4;
    id_inst_nxt    = id_inst;
    id_pc4_nxt     = id_pc4;
    id_valid_nxt   = id_valid;
    imem_req       = 1'b0;
    imem_addr      = pc;

    case (state)
      FETCH: begin
        imem_req = ~rst;
        if (imem_ready) begin
          if (hold) begin
            buf_inst_nxt = imem_rdata;
            buf_pc4_nxt  = pc_inc;
            pc_nxt       = pc_inc;
            state_nxt    = HOLD;
          end else if (redir) begin
            pc_nxt       = branch_target;
            id_valid_nxt = 1'b0;
          end else begin
            id_inst_nxt  = imem_rdata;
            id_pc4_nxt   = pc_inc;
            id_valid_nxt = 1'b1;
            pc_nxt       = pc_inc;
          end
        end else if (redir) begin
          // The outstanding request at pc must still complete before the redirect target is issued.
          drain_addr_nxt = pc;
          pc_nxt         = branch_target;
          id_valid_nxt   = 1'b0;
          state_nxt      = DRAIN;
        end else if (!hold) begin
          id_valid_nxt = 1'b0;
        end
      end

      HOLD: begin
        if (!hold) begin
          state_nxt = FETCH;
          if (redir) begin
            pc_nxt       = branch_target;
            id_valid_nxt = 1'b0;
          end else begin
            id_inst_nxt  = buf_inst;
            id_pc4_nxt   = buf_pc4;
            id_valid_nxt = 1'b1;
          end
        end
      end

      DRAIN: begin
        imem_req  = ~rst;
        imem_addr = drain_addr;
        if (imem_ready) begin
          state_nxt = FETCH;
        end
      end

      default: begin
        state_nxt = FETCH;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= FETCH;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc         <= RESET_PC;
      drain_addr <= 32'd0;
      buf_inst   <= 32'd0;
      buf_pc4    <= 32'd0;
      id_inst    <= 32'd0;
      id_pc4     <= 32'd0;
      id_valid   <= 1'b0;
    end else begin
      pc         <= pc_nxt;
      drain_addr <= drain_addr_nxt;
      buf_inst   <= buf_inst_nxt;
      buf_pc4    <= buf_pc4_nxt;
      id_inst    <= id_inst_nxt;
      id_pc4     <= id_pc4_nxt;
      id_valid   <= id_valid_nxt;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: memory returns addr|1, expected IF/ID contents queued at issue.
module tb_fetch_unit;

  logic        clk;
  logic        rst;
  logic        stall;
  logic        remain_pc;
  logic        branch;
  logic [31:0] branch_target;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_rdata;
  logic [31:0] id_inst;
  logic [31:0] id_pc4;
  logic        id_valid;

  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] pc4;
  } exp_t;

  exp_t sb[$];
  exp_t exp;
  int   checks;
  int   errors;

  fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
    .clk          (clk),
    .rst          (rst),
    .stall        (stall),
    .remain_pc    (remain_pc),
    .branch       (branch),
    .branch_target(branch_target),
    .imem_req     (imem_req),
    .imem_addr    (imem_addr),
    .imem_ready   (imem_ready),
    .imem_rdata   (imem_rdata),
    .id_inst      (id_inst),
    .id_pc4       (id_pc4),
    .id_valid     (id_valid)
  );

  assign imem_rdata = imem_addr | 32'h1;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; stall = 1'b0; remain_pc = 1'b0; branch = 1'b0;
    branch_target = 32'h0; imem_ready = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; stall = 1'b1; remain_pc = 1'b1; branch = 1'b1;
    branch_target = 32'h55; imem_ready = 1'b1;
    tick();
    checks++;
    if (imem_req !== 1'b0) begin
      errors++; $display("FAIL reset_req: imem_req=%b expected 0", imem_req);
    end
    tick();
    checks++;
    if (id_valid !== 1'b0 || id_inst !== 32'h0 || id_pc4 !== 32'h0) begin
      errors++; $display("FAIL reset_ifid: valid=%b inst=%h pc4=%h expected 0/0/0", id_valid, id_inst, id_pc4);
    end
    stall = 1'b0; remain_pc = 1'b0; branch = 1'b0; imem_ready = 1'b0;
    rst = 1'b0;
    #1;
    checks++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin
      errors++; $display("FAIL reset_first: req=%b addr=%h expected 1/00000000", imem_req, imem_addr);
    end
  endtask

  task automatic test_sequential();
    logic [31:0] a;
    do_reset();
    imem_ready = 1'b1;
    a = 32'h0;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (imem_addr !== a) begin
        errors++; $display("FAIL seq_addr: addr=%h expected %h", imem_addr, a);
      end
      sb.push_back('{inst: a | 32'h1, pc4: a + 32'd4});
      a = a + 32'd4;
      tick();
      exp = sb.pop_front();
      checks++;
      if (id_valid !== 1'b1 || id_inst !== exp.inst || id_pc4 !== exp.pc4) begin
        errors++; $display("FAIL seq_ifid: valid=%b inst=%h pc4=%h expected 1/%h/%h", id_valid, id_inst, id_pc4, exp.inst, exp.pc4);
      end
    end
    // wait state with stall but no remain_pc: a plain bubble, pc holds
    imem_ready = 1'b0; stall = 1'b1;
    tick();
    checks++;
    if (id_valid !== 1'b0 || imem_addr !== 32'h10 || imem_req !== 1'b1) begin
      errors++; $display("FAIL seq_bubble: valid=%b addr=%h req=%b expected 0/00000010/1", id_valid, imem_addr, imem_req);
    end
    stall = 1'b0; imem_ready = 1'b1;
    sb.push_back('{inst: 32'h11, pc4: 32'h14});
    tick();
    exp = sb.pop_front();
    checks++;
    if (id_valid !== 1'b1 || id_inst !== exp.inst || id_pc4 !== exp.pc4) begin
      errors++; $display("FAIL seq_resume: valid=%b inst=%h pc4=%h expected 1/%h/%h", id_valid, id_inst, id_pc4, exp.inst, exp.pc4);
    end
  endtask

  task automatic test_ignore_invalid();
    do_reset();
    stall = 1'b1; remain_pc = 1'b1; branch = 1'b1; branch_target = 32'h300; imem_ready = 1'b1;
    checks++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin
      errors++; $display("FAIL ign_req: req=%b addr=%h expected 1/00000000", imem_req, imem_addr);
    end
    sb.push_back('{inst: 32'h1, pc4: 32'h4});
    tick();
    stall = 1'b0; remain_pc = 1'b0; branch = 1'b0;
    exp = sb.pop_front();
    checks++;
    if (id_valid !== 1'b1 || id_inst !== exp.inst || id_pc4 !== exp.pc4 || imem_addr !== 32'h4) begin
      errors++; $display("FAIL ign_ifid: valid=%b inst=%h pc4=%h addr=%h expected 1/%h/%h/00000004", id_valid, id_inst, id_pc4, imem_addr, exp.inst, exp.pc4);
    end
  endtask

  task automatic test_branch_ready();
    do_reset();
    imem_ready = 1'b1;
    sb.push_back('{inst: 32'h1, pc4: 32'h4});
    tick();
    exp = sb.pop_front();
    checks++;
    if (id_valid !== 1'b1 || id_inst !== exp.inst || id_pc4 !== exp.pc4) begin
      errors++; $display("FAIL br_pre: valid=%b inst=%h pc4=%h expected 1/%h/%h", id_valid, id_inst, id_pc4, exp.inst, exp.pc4);
    end
    branch = 1'b1; branch_target = 32'h100;
    tick();
    branch = 1'b0;
    checks++;
    if (id_valid !== 1'b0 || imem_addr !== 32'h100) begin
      errors++; $display("FAIL br_bubble: valid=%b addr=%h expected 0/00000100", id_valid, imem_addr);
    end
    sb.push_back('{inst: 32'h101, pc4: 32'h104});
    tick();
    exp = sb.pop_front();
    checks++;
    if (id_valid !== 1'b1 || id_inst !== exp.inst || id_pc4 !== exp.pc4) begin
      errors++; $display("FAIL br_target: valid=%b inst=%h pc4=%h expected 1/%h/%h", id_valid, id_inst, id_pc4, exp.inst, exp.pc4);
    end
  endtask

  task automatic test_branch_wait();
    do_reset();
    imem_ready = 1'b1;
    for (int i = 0; i < 2; i++) begin
      sb.push_back('{inst: 32'(i * 4 + 1), pc4: 32'(i * 4 + 4)});
      tick();
      exp = sb.pop_front();
      checks++;
      if (id_valid !== 1'b1 || id_inst !== exp.inst || id_pc4 !== exp.pc4) begin
        errors++; $display("FAIL drn_pre: valid=%b inst=%h pc4=%h expected 1/%h/%h", id_valid, id_inst, id_pc4, exp.inst, exp.pc4);
      end
    end
    imem_ready = 1'b0; branch = 1'b1; branch_target = 32'h100;
    tick();
    branch = 1'b0;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (imem_addr !== 32'h8 || imem_req !== 1'b1 || id_valid !== 1'b0) begin
        errors++; $display("FAIL drn_hold: cyc=%0d addr=%h req=%b valid=%b expected 00000008/1/0", i, imem_addr, imem_req, id_valid);
      end
      if (i == 2) imem_ready = 1'b1;
      tick();
    end
    checks++;
    if (id_valid !== 1'b0 || imem_addr !== 32'h100) begin
      errors++; $display("FAIL drn_done: valid=%b addr=%h expected 0/00000100", id_valid, imem_addr);
    end
    sb.push_back('{inst: 32'h101, pc4: 32'h104});
    tick();
    exp = sb.pop_front();
    checks++;
    if (id_valid !== 1'b1 || id_inst !== exp.inst || id_pc4 !== exp.pc4) begin
      errors++; $display("FAIL drn_target: valid=%b inst=%h pc4=%h expected 1/%h/%h", id_valid, id_inst, id_pc4, exp.inst, exp.pc4);
    end
  endtask

  task automatic test_hold();
    do_reset();
    imem_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      sb.push_back('{inst: 32'(i * 4 + 1), pc4: 32'(i * 4 + 4)});
      tick();
      exp = sb.pop_front();
      checks++;
      if (id_valid !== 1'b1 || id_inst !== exp.inst || id_pc4 !== exp.pc4) begin
        errors++; $display("FAIL hold_pre: valid=%b inst=%h pc4=%h expected 1/%h/%h", id_valid, id_inst, id_pc4, exp.inst, exp.pc4);
      end
    end
    // a branch coinciding with the hold must not redirect
    stall = 1'b1; remain_pc = 1'b1; branch = 1'b1; branch_target = 32'h200;
    sb.push_back('{inst: 32'hD, pc4: 32'h10});
    for (int i = 0; i < 2; i++) begin
      tick();
      checks++;
      if (imem_req !== 1'b0 || id_valid !== 1'b1 || id_inst !== 32'h9 || id_pc4 !== 32'hC) begin
        errors++; $display("FAIL hold_frozen: cyc=%0d req=%b valid=%b inst=%h pc4=%h expected 0/1/00000009/0000000c", i, imem_req, id_valid, id_inst, id_pc4);
      end
    end
    stall = 1'b0; remain_pc = 1'b0; branch = 1'b0;
    tick();
    exp = sb.pop_front();
    checks++;
    if (id_valid !== 1'b1 || id_inst !== exp.inst || id_pc4 !== exp.pc4 || imem_req !== 1'b1 || imem_addr !== 32'h10) begin
      errors++; $display("FAIL hold_release: valid=%b inst=%h pc4=%h req=%b addr=%h expected 1/%h/%h/1/00000010", id_valid, id_inst, id_pc4, imem_req, imem_addr, exp.inst, exp.pc4);
    end
    sb.push_back('{inst: 32'h11, pc4: 32'h14});
    tick();
    exp = sb.pop_front();
    checks++;
    if (id_valid !== 1'b1 || id_inst !== exp.inst || id_pc4 !== exp.pc4) begin
      errors++; $display("FAIL hold_next: valid=%b inst=%h pc4=%h expected 1/%h/%h", id_valid, id_inst, id_pc4, exp.inst, exp.pc4);
    end
  endtask

  task automatic test_hold_redirect();
    do_reset();
    imem_ready = 1'b1;
    sb.push_back('{inst: 32'h1, pc4: 32'h4});
    tick();
    exp = sb.pop_front();
    checks++;
    if (id_valid !== 1'b1 || id_inst !== exp.inst || id_pc4 !== exp.pc4) begin
      errors++; $display("FAIL hrd_pre: valid=%b inst=%h pc4=%h expected 1/%h/%h", id_valid, id_inst, id_pc4, exp.inst, exp.pc4);
    end
    stall = 1'b1; remain_pc = 1'b1;
    tick();
    stall = 1'b0; remain_pc = 1'b0; branch = 1'b1; branch_target = 32'h40;
    tick();
    branch = 1'b0;
    checks++;
    if (id_valid !== 1'b0 || imem_addr !== 32'h40 || imem_req !== 1'b1) begin
      errors++; $display("FAIL hrd_redir: valid=%b addr=%h req=%b expected 0/00000040/1", id_valid, imem_addr, imem_req);
    end
    sb.push_back('{inst: 32'h41, pc4: 32'h44});
    tick();
    exp = sb.pop_front();
    checks++;
    if (id_valid !== 1'b1 || id_inst !== exp.inst || id_pc4 !== exp.pc4) begin
      errors++; $display("FAIL hrd_target: valid=%b inst=%h pc4=%h expected 1/%h/%h", id_valid, id_inst, id_pc4, exp.inst, exp.pc4);
    end
  endtask

  task automatic test_reset_drain();
    do_reset();
    imem_ready = 1'b1;
    tick();
    imem_ready = 1'b0; branch = 1'b1; branch_target = 32'h100;
    tick();
    branch = 1'b0;
    checks++;
    if (imem_addr !== 32'h4 || id_valid !== 1'b0) begin
      errors++; $display("FAIL rdr_drain: addr=%h valid=%b expected 00000004/0", imem_addr, id_valid);
    end
    rst = 1'b1;
    #1;
    checks++;
    if (imem_req !== 1'b0) begin
      errors++; $display("FAIL rdr_req: imem_req=%b expected 0", imem_req);
    end
    tick();
    rst = 1'b0;
    #1;
    checks++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h0 || id_valid !== 1'b0) begin
      errors++; $display("FAIL rdr_after: req=%b addr=%h valid=%b expected 1/00000000/0", imem_req, imem_addr, id_valid);
    end
    imem_ready = 1'b1;
    sb.push_back('{inst: 32'h1, pc4: 32'h4});
    tick();
    exp = sb.pop_front();
    checks++;
    if (id_valid !== 1'b1 || id_inst !== exp.inst || id_pc4 !== exp.pc4) begin
      errors++; $display("FAIL rdr_first: valid=%b inst=%h pc4=%h expected 1/%h/%h", id_valid, id_inst, id_pc4, exp.inst, exp.pc4);
    end
  endtask

  task automatic test_wrap();
    do_reset();
    imem_ready = 1'b1;
    tick();
    branch = 1'b1; branch_target = 32'hFFFF_FFFC;
    tick();
    branch = 1'b0;
    checks++;
    if (imem_addr !== 32'hFFFF_FFFC) begin
      errors++; $display("FAIL wrap_addr: addr=%h expected fffffffc", imem_addr);
    end
    sb.push_back('{inst: 32'hFFFF_FFFD, pc4: 32'h0});
    tick();
    exp = sb.pop_front();
    checks++;
    if (id_valid !== 1'b1 || id_inst !== exp.inst || id_pc4 !== exp.pc4 || imem_addr !== 32'h0) begin
      errors++; $display("FAIL wrap_ifid: valid=%b inst=%h pc4=%h addr=%h expected 1/%h/%h/00000000", id_valid, id_inst, id_pc4, imem_addr, exp.inst, exp.pc4);
    end
    sb.push_back('{inst: 32'h1, pc4: 32'h4});
    tick();
    exp = sb.pop_front();
    checks++;
    if (id_valid !== 1'b1 || id_inst !== exp.inst || id_pc4 !== exp.pc4) begin
      errors++; $display("FAIL wrap_next: valid=%b inst=%h pc4=%h expected 1/%h/%h", id_valid, id_inst, id_pc4, exp.inst, exp.pc4);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b1; stall = 1'b0; remain_pc = 1'b0; branch = 1'b0;
    branch_target = 32'h0; imem_ready = 1'b0;
    test_reset();
    test_sequential();
    test_ignore_invalid();
    test_branch_ready();
    test_branch_wait();
    test_hold();
    test_hold_redirect();
    test_reset_drain();
    test_wrap();
    checks++;
    if (sb.size() != 0) begin
      errors++; $display("FAIL sb_empty: %0d entries left, expected 0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, the first fetch address after reset.
REQ-002 SHALL have port clk  in  1  rising-edge clock; the block uses one clock only.
REQ-003 SHALL have port rst  in  1  reset; synchronous, active-high.
REQ-004 SHALL have port stall  in  1  stall request from the decode control.
REQ-005 SHALL have port remain_pc  in  1  with stall, marks a load-use hold of PC and IF/ID.
REQ-006 SHALL have port branch  in  1  taken branch, jump, jal or jr resolved in ID.
REQ-007 SHALL have port branch_target  in  32  redirect address, valid when branch=1.
REQ-008 SHALL have port imem_req  out  1  instruction memory request.
REQ-009 SHALL have port imem_addr  out  32  fetch address; stable while imem_req=1 and imem_ready=0.
REQ-010 SHALL have port imem_ready  in  1  request accepted, with imem_rdata valid in the same cycle.
REQ-011 SHALL have port imem_rdata  in  32  fetched instruction word.
REQ-012 SHALL have port id_inst  out  32  IF/ID instruction.
REQ-013 SHALL have port id_pc4  out  32  IF/ID address of the instruction + 4.
REQ-014 SHALL have port id_valid  out  1  IF/ID holds a real instruction (0 = bubble).

Function
REQ-015 SHALL define hold = id_valid & stall & remain_pc and redir = id_valid & branch & ~hold; when id_valid=0, stall, remain_pc and branch SHALL be ignored.
REQ-016 SHALL implement states FETCH, HOLD and DRAIN, plus registers pc, drain_addr, buf_inst and buf_pc4.
REQ-017 SHALL drive imem_req=1 in FETCH and DRAIN, and imem_req=0 in HOLD.
REQ-018 SHALL drive imem_addr = drain_addr in DRAIN, otherwise pc.
REQ-019 All pc increments SHALL be pc+4 modulo 2^32, wrapping 32'hFFFF_FFFC to 0.
REQ-020 In FETCH with imem_ready=1 and hold:
- buf_inst<=imem_rdata, buf_pc4<=pc+4, pc<=pc+4
- IF/ID unchanged
- next state HOLD
REQ-021 In FETCH with imem_ready=1 and redir:
- rdata discarded
- pc<=branch_target, id_valid<=0
- stay in FETCH
REQ-022 In FETCH with imem_ready=1 and neither hold nor redir:
- id_inst<=imem_rdata, id_pc4<=pc+4, id_valid<=1
- pc<=pc+4
REQ-023 In FETCH with imem_ready=0:
- hold: IF/ID unchanged
- redir: drain_addr<=pc, pc<=branch_target, id_valid<=0, next state DRAIN
- otherwise: id_valid<=0 (bubble)
REQ-024 In HOLD:
- hold still asserted: remain in HOLD, IF/ID and buffer unchanged
- hold deasserted with redir: buffer discarded, pc<=branch_target, id_valid<=0, next state FETCH
- hold deasserted without redir: IF/ID<={buf_inst, buf_pc4, 1}, next state FETCH
REQ-025 In DRAIN:
- imem_addr SHALL stay drain_addr until imem_ready=1
- on imem_ready=1: rdata discarded, next state FETCH
- id_valid stays 0; pc is not altered
REQ-026 Fetch latency SHALL be: IF/ID is updated at the clock edge where imem_ready=1; zero-wait memory gives one instruction per cycle.
REQ-027 When hold and redir coincide, hold SHALL win: no redirect is taken in that cycle.

Reset
REQ-028 When rst=1 at a clock edge:
- state<=FETCH, pc<=RESET_PC
- id_inst<=0, id_pc4<=0, id_valid<=0
- drain_addr, buf_inst and buf_pc4 <=0
REQ-029 While rst=1, imem_req SHALL be 0; any in-flight request SHALL be abandoned without a drain.
REQ-030 The first cycle after rst deasserts SHALL present imem_req=1 with imem_addr=RESET_PC.

Verification
REQ-031 Zero-wait memory, rdata=addr|1, no stall/branch -> id_pc4 = 4, 8, 12 on consecutive cycles, with id_valid=1 from cycle 1.
REQ-032 Branch taken with ready=1, branch_target=32'h100 -> id_valid=0 for one cycle, then id_pc4=32'h104.
REQ-033 Branch taken while ready=0 at pc=8, then ready after 3 cycles:
- imem_addr holds 8 through the drain
- then addr=32'h100
- the instruction fetched at 8 never reaches IF/ID
REQ-034 Hold for 2 cycles while ready=1 at pc=12:
- imem_req=0 in HOLD
- IF/ID unchanged during the hold
- then id_pc4=16 from the buffer, then the next fetch at 16
REQ-035 Reset mid-DRAIN: rst pulse -> next cycle imem_addr=RESET_PC, id_valid=0, no discarded fetch pending.
REQ-036 pc=32'hFFFF_FFFC, zero-wait memory -> id_pc4=0, next imem_addr=0.
